// File: rtl/fifo_controller_d0_pkg.sv
// Shared definitions for the FIFO controller.
//   fifo_state_e : controller FSM state (init sweep, then normal run)
//   fifo_depth() : RAM depth for a given address width
package fifo_controller_d0_pkg;

    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } fifo_state_e;

    function automatic int unsigned fifo_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/fifo_ptr_d0.sv
// Wrap-around address pointer with increment enable and synchronous clear.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset, pointer returns to 0
//   clr_i  : synchronous clear to 0 (wins over inc_i)
//   inc_i  : advance by one, wrapping modulo 2**Width
//   ptr_o  : current pointer value
module fifo_ptr_d0 #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] ptr_o
);

    logic [Width-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            // natural overflow of the Width-bit sum gives the wrap
            ptr_d = ptr_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_controller_d0.sv
// Synchronous FIFO controller driving one external RAM (first-word fall-through).
// After reset it zero-fills the whole RAM, then serves push/pop/flush.
//   clk, reset_L            : clock (rising edge), async active-low reset
//   push, push_data         : enqueue request and word
//   pop                     : dequeue request (head word is on the RAM data_out)
//   flush                   : synchronous empty command, overrides push/pop
//   alm_full_thr/alm_empty_thr : almost-flag thresholds
//   ram_write/ram_read/ram_data_in/wr_ptr/rd_ptr : RAM control
//   init_done, full, empty, almost_full, almost_empty, count : status
//   overflow/underflow      : sticky dropped-push / rejected-pop indicators
module fifo_controller_d0
    import fifo_controller_d0_pkg::*;
#(
    parameter int unsigned DATA_SIZE       = 10,
    parameter int unsigned MAIN_QUEUE_SIZE = 8
) (
    input  logic                       clk,
    input  logic                       reset_L,
    input  logic                       push,
    input  logic [DATA_SIZE-1:0]       push_data,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [MAIN_QUEUE_SIZE:0]   alm_full_thr,
    input  logic [MAIN_QUEUE_SIZE:0]   alm_empty_thr,
    output logic                       ram_write,
    output logic                       ram_read,
    output logic [DATA_SIZE-1:0]       ram_data_in,
    output logic [MAIN_QUEUE_SIZE-1:0] wr_ptr,
    output logic [MAIN_QUEUE_SIZE-1:0] rd_ptr,
    output logic                       init_done,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [MAIN_QUEUE_SIZE:0]   count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned Depth = fifo_depth(MAIN_QUEUE_SIZE);
    localparam logic [MAIN_QUEUE_SIZE:0]   DepthCnt = Depth[MAIN_QUEUE_SIZE:0];
    localparam logic [MAIN_QUEUE_SIZE-1:0] LastAddr = '1;

    fifo_state_e                state_q, state_d;
    logic [MAIN_QUEUE_SIZE:0]   count_q, count_d;
    logic                       overflow_q, overflow_d;
    logic                       underflow_q, underflow_d;

    logic run, cnt_full, cnt_empty, acc_push, acc_pop, ptr_clr, wr_inc;

    always_comb begin
        run       = (state_q == StRun);
        cnt_full  = (count_q == DepthCnt);
        cnt_empty = (count_q == '0);
        // a pop frees the slot the same-cycle push writes into, so a full FIFO
        // can still accept a push alongside an accepted pop
        acc_pop   = run & ~flush & pop & ~cnt_empty;
        acc_push  = run & ~flush & push & (~cnt_full | acc_pop);
        ptr_clr   = run & flush;
        // the init sweep reuses the write pointer as its address counter
        wr_inc    = ~run | acc_push;
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        unique case (state_q)
            StInit: begin
                if (wr_ptr == LastAddr) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (flush) begin
                    count_d = '0;
                end else begin
                    if (acc_push && !acc_pop) begin
                        count_d = count_q + 1'b1;
                    end else if (acc_pop && !acc_push) begin
                        count_d = count_q - 1'b1;
                    end
                    overflow_d  = overflow_q | (push & ~acc_push);
                    underflow_d = underflow_q | (pop & ~acc_pop);
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= StInit;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ptr_d0 #(
        .Width (MAIN_QUEUE_SIZE)
    ) u_wr_ptr (
        .clk_i  (clk),
        .rst_ni (reset_L),
        .clr_i  (ptr_clr),
        .inc_i  (wr_inc),
        .ptr_o  (wr_ptr)
    );

    fifo_ptr_d0 #(
        .Width (MAIN_QUEUE_SIZE)
    ) u_rd_ptr (
        .clk_i  (clk),
        .rst_ni (reset_L),
        .clr_i  (ptr_clr),
        .inc_i  (acc_pop),
        .ptr_o  (rd_ptr)
    );

    // reset_L gates the write strobe so the RAM is never written while held in reset
    assign ram_write    = reset_L & (~run | acc_push);
    assign ram_read     = acc_pop;
    assign ram_data_in  = run ? push_data : '0;
    assign init_done    = run;
    assign full         = ~run | cnt_full;
    assign empty        = ~run | cnt_empty;
    assign almost_full  = (count_q >= alm_full_thr);
    assign almost_empty = (count_q <= alm_empty_thr);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_controller_d0.sv
module tb_fifo_controller_d0;

    localparam int AW    = 2;
    localparam int DW    = 10;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          push = 1'b0, pop = 1'b0, flush = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic [AW:0]   alm_full_thr = 3'd3;
    logic [AW:0]   alm_empty_thr = 3'd1;

    logic          ram_write, ram_read, init_done, full, empty;
    logic          almost_full, almost_empty, overflow, underflow;
    logic [DW-1:0] ram_data_in;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    fifo_controller_d0 #(
        .DATA_SIZE       (DW),
        .MAIN_QUEUE_SIZE (AW)
    ) dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .push          (push),
        .push_data     (push_data),
        .pop           (pop),
        .flush         (flush),
        .alm_full_thr  (alm_full_thr),
        .alm_empty_thr (alm_empty_thr),
        .ram_write     (ram_write),
        .ram_read      (ram_read),
        .ram_data_in   (ram_data_in),
        .wr_ptr        (wr_ptr),
        .rd_ptr        (rd_ptr),
        .init_done     (init_done),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    // RAM emulation: write at the edge, combinational read at rd_ptr
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_dout;
    assign ram_dout = mem[rd_ptr];

    logic          pend_we = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    logic [DW-1:0] pend_data = '0;

    // Reference model: queue of words plus pointer/flag bookkeeping
    int m_init_left = DEPTH;
    int m_q[$];
    int m_wr = 0, m_rd = 0;
    bit m_ovf = 1'b0, m_unf = 1'b0;
    bit chk_en = 1'b0;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        tests++;
        if (act !== 32'(exp)) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_init_left = DEPTH;
        m_q.delete();
        m_wr = 0;
        m_rd = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step();
        int  n;
        bit  ap, apu;
        if (m_init_left > 0) begin
            m_init_left--;
        end else if (flush) begin
            m_q.delete();
            m_wr = 0;
            m_rd = 0;
        end else begin
            n   = m_q.size();
            ap  = pop && (n > 0);
            apu = push && ((n < DEPTH) || ap);
            if (ap) begin
                void'(m_q.pop_front());
                m_rd = (m_rd + 1) % DEPTH;
            end else if (pop) begin
                m_unf = 1'b1;
            end
            if (apu) begin
                m_q.push_back(int'(push_data));
                m_wr = (m_wr + 1) % DEPTH;
            end else if (push) begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic compare();
        int n;
        bit ap, apu;
        if (!reset_L) begin
            chk("reset_ram_write", ram_write, 0);
            chk("reset_count", count, 0);
            chk("reset_init_done", init_done, 0);
            chk("reset_wr_ptr", wr_ptr, 0);
            chk("reset_rd_ptr", rd_ptr, 0);
            chk("reset_overflow", overflow, 0);
            chk("reset_underflow", underflow, 0);
        end else if (m_init_left > 0) begin
            chk("init_ram_write", ram_write, 1);
            chk("init_ram_read", ram_read, 0);
            chk("init_data_in", ram_data_in, 0);
            chk("init_wr_ptr", wr_ptr, DEPTH - m_init_left);
            chk("init_rd_ptr", rd_ptr, 0);
            chk("init_done_low", init_done, 0);
            chk("init_full", full, 1);
            chk("init_empty", empty, 1);
            chk("init_count", count, 0);
            chk("init_overflow", overflow, int'(m_ovf));
            chk("init_underflow", underflow, int'(m_unf));
        end else begin
            n   = m_q.size();
            ap  = pop && !flush && (n > 0);
            apu = push && !flush && ((n < DEPTH) || ap);
            chk("run_init_done", init_done, 1);
            chk("run_count", count, n);
            chk("run_full", full, int'(n == DEPTH));
            chk("run_empty", empty, int'(n == 0));
            chk("run_almost_full", almost_full, int'(n >= int'(alm_full_thr)));
            chk("run_almost_empty", almost_empty, int'(n <= int'(alm_empty_thr)));
            chk("run_ram_write", ram_write, int'(apu));
            chk("run_ram_read", ram_read, int'(ap));
            chk("run_data_in", ram_data_in, int'(push_data));
            chk("run_wr_ptr", wr_ptr, m_wr);
            chk("run_rd_ptr", rd_ptr, m_rd);
            chk("run_overflow", overflow, int'(m_ovf));
            chk("run_underflow", underflow, int'(m_unf));
            if (n > 0) chk("run_head_word", ram_dout, m_q[0]);
        end
    endtask

    // compare on the falling edge, also latch the RAM write for the next rising edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) compare();
            pend_we   = ram_write;
            pend_addr = wr_ptr;
            pend_data = ram_data_in;
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 10'h3FF;
        forever begin
            @(posedge clk or negedge reset_L);
            if (!reset_L) begin
                model_reset();
                pend_we = 1'b0;
            end else begin
                if (pend_we) mem[pend_addr] = pend_data;
                pend_we = 1'b0;
                model_step();
            end
        end
    end

    task automatic set_in(input bit p, input int d, input bit o, input bit f);
        push      = p;
        push_data = DW'(d);
        pop       = o;
        flush     = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_init_sweep(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, 'h3AB, 1'b1, 1'b1);  // must all be ignored
            #1;
            chk({tag, "_we"}, ram_write, 1);
            chk({tag, "_wptr"}, wr_ptr, i);
            chk({tag, "_din"}, ram_data_in, 0);
            tick();
        end
        set_in(1'b0, 0, 1'b0, 1'b0);
        #1;
        chk({tag, "_done"}, init_done, 1);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_wptr_wrap"}, wr_ptr, 0);
        chk({tag, "_no_ovf"}, overflow, 0);
        chk({tag, "_no_unf"}, underflow, 0);
        chk({tag, "_we_off"}, ram_write, 0);
    endtask

    int exp_heads[6] = '{'h0AA, 'h066, 'h100, 'h101, 'h102, 'h103};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("por_count", count, 0);
        chk("por_ram_write", ram_write, 0);
        chk("por_init_done", init_done, 0);
        reset_L = 1'b1;
        check_init_sweep("sweep1");

        // fill to full
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 'h11 * (i + 1), 1'b0, 1'b0);
            tick();
            set_in(1'b0, 0, 1'b0, 1'b0);
            chk("fill_count", count, i + 1);
            if (i == 1) chk("fill_not_almost_full", almost_full, 0);
            if (i == 2) chk("fill_almost_full", almost_full, 1);
        end
        chk("fill_full", full, 1);

        // drain, head sequence in push order
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 0, 1'b1, 1'b0);
            #1;
            chk("drain_head", ram_dout, 'h11 * (i + 1));
            tick();
        end
        set_in(1'b0, 0, 1'b0, 1'b0);
        chk("drain_empty", empty, 1);

        // pop while empty
        set_in(1'b0, 0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 0, 1'b0, 1'b0);
        chk("unf_set", underflow, 1);
        chk("unf_rd_ptr", rd_ptr, 0);

        // push+pop while empty: push wins
        set_in(1'b1, 'h077, 1'b1, 1'b0);
        #1;
        chk("emptypp_we", ram_write, 1);
        chk("emptypp_re", ram_read, 0);
        tick();
        set_in(1'b0, 0, 1'b0, 1'b0);
        chk("emptypp_count", count, 1);

        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 'h088 + 'h11 * i, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, 0, 1'b0, 1'b0);
        chk("refill_full", full, 1);

        // push into full alone: dropped
        set_in(1'b1, 'h055, 1'b0, 1'b0);
        #1;
        chk("ovf_no_we", ram_write, 0);
        tick();
        set_in(1'b0, 0, 1'b0, 1'b0);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 4);

        // push+pop while full: both accepted
        set_in(1'b1, 'h066, 1'b1, 1'b0);
        #1;
        chk("fullpp_we", ram_write, 1);
        chk("fullpp_re", ram_read, 1);
        chk("fullpp_head", ram_dout, 'h077);
        tick();
        set_in(1'b0, 0, 1'b0, 1'b0);
        chk("fullpp_count", count, 4);
        chk("fullpp_wr_ptr", wr_ptr, 1);
        chk("fullpp_rd_ptr", rd_ptr, 1);

        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 0, 1'b1, 1'b0);
            tick();
        end
        set_in(1'b0, 0, 1'b0, 1'b0);
        chk("mid_count", count, 2);

        // steady push/pop pairs wrap both pointers
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 'h100 + i, 1'b1, 1'b0);
            #1;
            chk("wrap_head", ram_dout, exp_heads[i]);
            tick();
        end
        set_in(1'b0, 0, 1'b0, 1'b0);
        chk("wrap_count", count, 2);
        chk("wrap_rd_ptr", rd_ptr, 1);
        chk("wrap_wr_ptr", wr_ptr, 3);
        chk("wrap_head_after", ram_dout, 'h104);

        set_in(1'b1, 'h1FF, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 0, 1'b0, 1'b0);
        chk("preflush_count", count, 3);

        // flush with push: no write, state cleared, sticky flags kept
        set_in(1'b1, 'h2AA, 1'b0, 1'b1);
        #1;
        chk("flush_no_we", ram_write, 0);
        tick();
        set_in(1'b0, 0, 1'b0, 1'b0);
        chk("flush_count", count, 0);
        chk("flush_wr_ptr", wr_ptr, 0);
        chk("flush_rd_ptr", rd_ptr, 0);
        chk("flush_ovf_kept", overflow, 1);
        chk("flush_unf_kept", underflow, 1);
        chk("flush_no_init", init_done, 1);

        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 'h200 + i, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, 0, 1'b0, 1'b0);
        chk("prereset_count", count, 2);

        // asynchronous reset mid-cycle
        #2;
        reset_L = 1'b0;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_wr_ptr", wr_ptr, 0);
        chk("midrst_init_done", init_done, 0);
        chk("midrst_ram_write", ram_write, 0);
        chk("midrst_overflow", overflow, 0);
        tick();
        tick();
        reset_L = 1'b1;
        check_init_sweep("sweep2");
        chk("rezero_0", mem[0], 0);
        chk("rezero_1", mem[1], 0);

        set_in(1'b1, 'h123, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 0, 1'b0, 1'b0);
        chk("post_head", ram_dout, 'h123);
        chk("post_count", count, 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_controller_d0.md
Name: fifo_controller_d0

Overview:
Pointer and flag controller that sequences one RAM_memory_d0 instance as a synchronous FIFO.
- Generates wr_ptr, rd_ptr, write and read for the RAM.
- Muxes write data into the RAM.
- Tracks occupancy and raises full, empty, almost-full and almost-empty flags.
- After every reset it runs a zero-initialisation sweep over the whole RAM, because the memory has no reset of its own.

Parameters:
DATA_SIZE, 10, data word width; must match the RAM.
MAIN_QUEUE_SIZE, 8, address width in bits; depth DEPTH = 2**MAIN_QUEUE_SIZE.

Ports:
clk  input  1  single clock, rising edge.
reset_L  input  1  asynchronous active-low reset.
push  input  1  requester writes push_data this cycle.
push_data  input  DATA_SIZE  word to enqueue.
pop  input  1  consumer takes the head word this cycle (head word is on the RAM data_out).
flush  input  1  synchronous empty-the-FIFO command.
alm_full_thr  input  MAIN_QUEUE_SIZE+1  almost_full threshold.
alm_empty_thr  input  MAIN_QUEUE_SIZE+1  almost_empty threshold.
ram_write  output  1  RAM write enable.
ram_read  output  1  RAM read enable.
ram_data_in  output  DATA_SIZE  RAM write data.
wr_ptr  output  MAIN_QUEUE_SIZE  RAM write address.
rd_ptr  output  MAIN_QUEUE_SIZE  RAM read address.
init_done  output  1  high once the init sweep has finished.
full  output  1  FIFO full.
empty  output  1  FIFO empty.
almost_full  output  1  almost-full flag.
almost_empty  output  1  almost-empty flag.
count  output  MAIN_QUEUE_SIZE+1  current occupancy.
overflow  output  1  sticky: a push was dropped.
underflow  output  1  sticky: a pop was rejected.

Behaviour:
- Reset (reset_L low, asynchronous):
  - state=INIT; wr_ptr=0, rd_ptr=0, count=0; overflow=0, underflow=0; init_done=0.
  - While in reset, ram_write=0.
- Two-state FSM: INIT -> RUN.
- INIT:
  - ram_write=1, ram_data_in=0, wr_ptr increments each cycle from 0 to DEPTH-1.
  - On the cycle that writes DEPTH-1: wr_ptr wraps to 0 and state becomes RUN.
  - INIT lasts exactly DEPTH cycles after reset release.
  - push, pop and flush are ignored and flag no errors. full=1, empty=1, ram_read=0.
- RUN: init_done=1; ram_data_in = push_data.
  - acc_pop = pop & (count != 0).
  - acc_push = push & ((count != DEPTH) | acc_pop). A push into a full FIFO is accepted only with a same-cycle accepted pop. The head word is read combinationally before the edge overwrites it.
  - Push while empty with a simultaneous pop: the push is accepted, the pop is rejected and underflow sets.
  - ram_write = acc_push; ram_read = acc_pop. Both are combinational from the inputs and state.
  - At the clock edge:
    - acc_push: wr_ptr+1, modulo DEPTH.
    - acc_pop: rd_ptr+1, modulo DEPTH.
    - count: +1, -1, or unchanged when both or neither are accepted.
  - push & !acc_push: overflow=1. pop & !acc_pop: underflow=1. Both stay set until reset.
- flush in RUN has priority:
  - push and pop are ignored that cycle and ram_write=0.
  - Next cycle wr_ptr=rd_ptr=0 and count=0; overflow and underflow are kept.
  - No re-init sweep.
- Flags, combinational from count:
  - full = (count==DEPTH); empty = (count==0).
  - almost_full = (count >= alm_full_thr); almost_empty = (count <= alm_empty_thr).
- Read latency: the head word is valid on the RAM data_out whenever !empty (first-word fall-through). A push becomes visible at the head on the cycle after the push edge.
- Reset mid-operation: all state is lost and INIT restarts; the FIFO contents are re-zeroed.

Decomposition:
- Shared package: FSM state encoding (INIT=1'b0, RUN=1'b1) and DEPTH derived from MAIN_QUEUE_SIZE.
- Natural sub-module: fifo_ptr_d0, a wrap-around pointer register with an increment enable and a synchronous clear. Instantiate it twice (write pointer, read pointer). The count and flag logic stays in the top module.

Test Plan (MAIN_QUEUE_SIZE=2, DEPTH=4, DATA_SIZE=10, alm_full_thr=3, alm_empty_thr=1):
- Reset release -> ram_write=1 for exactly 4 cycles with wr_ptr 0,1,2,3 and ram_data_in=0. Then init_done=1, empty=1, count=0, wr_ptr=0.
- Push 0x011,0x022,0x033,0x044 -> count 1..4; almost_full at count=3; full=1 after the 4th push. Then pop 4 times -> the RAM data_out sequence is 0x011,0x022,0x033,0x044, ending with empty=1.
- When full, push 0x055 alone -> no ram_write, overflow=1, count stays 4. Then push 0x066 with pop -> both accepted, count stays 4, wr_ptr and rd_ptr both advance.
- When empty, pop alone -> underflow=1, rd_ptr unchanged. Then push+pop together -> the push is accepted and count=1.
- 6 push/pop pairs at count=2 -> pointers wrap 3->0 and the data order is preserved.
- At count=3, assert flush together with push -> next cycle count=0, both pointers 0, no write, overflow unchanged.
- Assert reset_L low mid-stream at count=2 -> outputs clear immediately; a new 4-cycle INIT sweep runs after release.
